mem_stage: RTL and testbench
============================

# mem_stage

MIPS pipeline memory-access stage plus the MEM/WB pipeline register. Consumes the EX/MEM register outputs, resolves the branch (PCSrc), performs loads/stores over a request/acknowledge data-memory port with variable latency, and registers the writeback bundle. It raises a stall while an access is outstanding; upstream stages hold while the stall is high.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Add_in  in  32  branch target from EX/MEM
- ALU_in  in  32  ALU result / memory address
- B2_in  in  32  store data
- Mux_in  in  5  destination register number
- ZF_in  in  1  ALU zero flag
- Branch_in, MemToWrite_in, MemRead_in, Regwrite_in, MemToReg_in  in  1 each  control bits from EX/MEM
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = store, 0 = load; valid while mem_req
- mem_addr  out  32  word address; valid while mem_req
- mem_wdata  out  32  = B2_in
- mem_rdata  in  32  load data, sampled only in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse
- PCSrc_out  out  1  combinational Branch_in & ZF_in
- BranchTarget_out  out  32  combinational = Add_in
- Stall_out  out  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM
- Regwrite_out, MemToReg_out  out  1  registered MEM/WB control
- ReadData_out, ALU_out  out  32  registered MEM/WB data
- Mux_out  out  5  registered destination register
- Misalign_out  out  1  registered alignment-fault flag (see Configuration)

## Operation
- Access = MemRead_in | MemToWrite_in. If both are set, the access is treated as a store.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - No access: Stall_out=0, mem_req=0; MEM/WB captures inputs.
  - Access: mem_req=1, Stall_out=1.
  - If mem_ack in the same cycle, go to DONE (capture mem_rdata if load); otherwise go to WAIT.
- WAIT: mem_req=1, Stall_out=1; on mem_ack go to DONE, capturing mem_rdata if load.
- DONE: mem_req=0, Stall_out=0; MEM/WB captures the instruction with the held load data; next state IDLE.
- While Stall_out=1, MEM/WB loads a bubble: Regwrite_out=0, MemToReg_out=0, Misalign_out=0, other fields don't-care (drive 0).
- Stores: ReadData_out loads 0.
- Non-memory instructions: ReadData_out loads 0.
- mem_ack outside IDLE-with-access or WAIT is ignored.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from request to ack, because upstream holds under stall.
- PCSrc_out and BranchTarget_out are pure pass-through logic, independent of state.
- While rst=1: mem_req, Stall_out and PCSrc_out are forced 0.

## Timing
- Reset: state IDLE; Regwrite_out, MemToReg_out, ReadData_out, ALU_out, Mux_out and Misalign_out all 0.
- Non-memory instruction: 1 cycle (MEM/WB valid the cycle after the inputs present).
- Memory instruction, ack in cycle k (k≥0) after presentation: Stall_out high for cycles 0..k; DONE in cycle k+1; MEM/WB valid in cycle k+2.
- Reset asserted in WAIT: the request is abandoned; state IDLE next cycle; a late mem_ack is ignored.
- Back-to-back memory instructions: each starts a fresh IDLE→WAIT/DONE sequence; no overlap.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An access with ALU_in[1:0]≠0 issues no mem_req and no stall; the stage completes in 1 cycle.
  - MEM/WB loads Regwrite_out=0, MemToReg_out=0, Misalign_out=1 for one cycle.
  - mem_addr = ALU_in.
- Not defined:
  - mem_addr = {ALU_in[31:2], 2'b00}; no fault detection.
  - Misalign_out is tied 0.

## Test plan
- Reset, then a non-memory instruction (ALU_in=0x1234, Mux_in=5, Regwrite_in=1) -> next cycle ALU_out=0x1234, Mux_out=5, Regwrite_out=1, Stall_out never high.
- Load from 0x40 with mem_ack 3 cycles later, mem_rdata=0xDEADBEEF -> Stall_out high 4 cycles; bubble in MEM/WB meanwhile; then ReadData_out=0xDEADBEEF, MemToReg_out=1, Regwrite_out=1.
- Store with same-cycle ack (B2_in=0xA5A5A5A5) -> mem_we=1, mem_wdata=0xA5A5A5A5; Stall_out high 1 cycle; Regwrite_out=0, ReadData_out=0.
- Branch_in=1, ZF_in=1, Add_in=0x100 -> PCSrc_out=1 and BranchTarget_out=0x100 in the same cycle; with ZF_in=0 -> PCSrc_out=0.
- rst pulsed during WAIT, then a stray mem_ack -> mem_req and Stall_out drop; all registered outputs 0; state IDLE; the ack is ignored.
- Load at 0x42: with MEM_ALIGN_CHECK_EN -> no mem_req, Misalign_out=1 for one cycle, Regwrite_out=0; without it -> mem_addr=0x40, normal load.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with MEM/WB register and req/ack data port; define MEM_ALIGN_CHECK_EN to fault misaligned accesses
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Add_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] B2_in,
  input  logic [4:0]  Mux_in,
  input  logic        ZF_in,
  input  logic        Branch_in,
  input  logic        MemToWrite_in,
  input  logic        MemRead_in,
  input  logic        Regwrite_in,
  input  logic        MemToReg_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        PCSrc_out,
  output logic [31:0] BranchTarget_out,
  output logic        Stall_out,
  output logic        Regwrite_out,
  output logic        MemToReg_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  Mux_out,
  output logic        Misalign_out
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic access, is_load, misalign, req;
  assign access = MemRead_in | MemToWrite_in;
  assign is_load = MemRead_in & ~MemToWrite_in;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access & (ALU_in[1:0] != 2'b00);
  assign mem_addr = ALU_in;
`else
  assign misalign = 1'b0;
  assign mem_addr = {ALU_in[31:2], 2'b00};
`endif
  // a request is live from the first access cycle in IDLE through the ack cycle
  assign req = ~rst & ((state_q == WAIT) | ((state_q == IDLE) & access & ~misalign));
  assign mem_req = req;
  assign Stall_out = req;
  assign mem_we = MemToWrite_in;
  assign mem_wdata = B2_in;
  assign PCSrc_out = ~rst & Branch_in & ZF_in;
  assign BranchTarget_out = Add_in;
  always_comb begin
    state_d = state_q == DONE ? IDLE : req ? (mem_ack ? DONE : WAIT) : state_q;
    rdata_d = req & mem_ack & is_load ? mem_rdata : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      Regwrite_out <= 1'b0;
      MemToReg_out <= 1'b0;
      Misalign_out <= 1'b0;
      ReadData_out <= '0;
      ALU_out <= '0;
      Mux_out <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      Regwrite_out <= ~req & Regwrite_in & ~misalign;
      MemToReg_out <= ~req & MemToReg_in & ~misalign;
      Misalign_out <= ~req & misalign;
      ReadData_out <= ~req & (state_q == DONE) & is_load ? rdata_q : '0;
      ALU_out <= req ? '0 : ALU_in;
      Mux_out <= req ? '0 : Mux_in;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a per-instruction reference model
module tb_mem_stage;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] Add_in, ALU_in, B2_in, mem_rdata;
  logic [4:0] Mux_in;
  logic ZF_in, Branch_in, MemToWrite_in, MemRead_in, Regwrite_in, MemToReg_in, mem_ack;
  logic mem_req, mem_we, PCSrc_out, Stall_out, Regwrite_out, MemToReg_out, Misalign_out;
  logic [31:0] mem_addr, mem_wdata, BranchTarget_out, ReadData_out, ALU_out;
  logic [4:0] Mux_out;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [31:0] add, alu, b2, rdata;
    logic [4:0] mux;
    logic zf, br, wr, rd, rw, mtr;
  } instr_t;
  always #5 clk = ~clk;
  mem_stage dut (
    .clk(clk), .rst(rst), .Add_in(Add_in), .ALU_in(ALU_in), .B2_in(B2_in), .Mux_in(Mux_in),
    .ZF_in(ZF_in), .Branch_in(Branch_in), .MemToWrite_in(MemToWrite_in), .MemRead_in(MemRead_in),
    .Regwrite_in(Regwrite_in), .MemToReg_in(MemToReg_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .PCSrc_out(PCSrc_out), .BranchTarget_out(BranchTarget_out), .Stall_out(Stall_out),
    .Regwrite_out(Regwrite_out), .MemToReg_out(MemToReg_out), .ReadData_out(ReadData_out),
    .ALU_out(ALU_out), .Mux_out(Mux_out), .Misalign_out(Misalign_out)
  );
  function automatic instr_t blank();
    instr_t t;
    t.add = '0; t.alu = '0; t.b2 = '0; t.rdata = '0; t.mux = '0;
    t.zf = 1'b0; t.br = 1'b0; t.wr = 1'b0; t.rd = 1'b0; t.rw = 1'b0; t.mtr = 1'b0;
    return t;
  endfunction
  function automatic instr_t rand_instr();
    instr_t t;
    t.add = $urandom; t.alu = $urandom; t.b2 = $urandom; t.rdata = $urandom; t.mux = 5'($urandom);
    t.zf = 1'($urandom); t.br = 1'($urandom); t.wr = 1'($urandom); t.rd = 1'($urandom);
    t.rw = 1'($urandom); t.mtr = 1'($urandom);
    return t;
  endfunction
  function automatic bit misaligned(input instr_t t);
    return ALIGN_CHK && (t.rd || t.wr) && t.alu[1:0] != 2'b00;
  endfunction
  task automatic apply(input instr_t t);
    Add_in = t.add; ALU_in = t.alu; B2_in = t.b2; Mux_in = t.mux; ZF_in = t.zf; Branch_in = t.br;
    MemToWrite_in = t.wr; MemRead_in = t.rd; Regwrite_in = t.rw; MemToReg_in = t.mtr;
  endtask
  // Runs one instruction whose ack arrives k cycles after presentation; entered and left at a negedge.
  task automatic exec(input instr_t t, input int k);
    bit mis, mem, ld, st;
    int cyc;
    logic [31:0] eaddr;
    mis = misaligned(t);
    mem = (t.rd || t.wr) && !mis;
    ld = t.rd && !t.wr;
    cyc = mem ? k + 2 : 1;
    eaddr = ALIGN_CHK ? t.alu : (t.alu & 32'hFFFF_FFFC);
    apply(t);
    for (int c = 0; c < cyc; c++) begin
      mem_ack = mem ? (c == k || (c == k + 1 && 1'($urandom))) : 1'($urandom);
      mem_rdata = (c == k) ? t.rdata : $urandom;
      #1;
      st = mem && c <= k;
      tests++;
      if ({Stall_out, mem_req, PCSrc_out, BranchTarget_out} !== {st, st, t.br & t.zf, t.add}) begin
        fails++;
        $display("FAIL comb c=%0d: got stall=%b req=%b pcsrc=%b tgt=%h, want stall=%b req=%b pcsrc=%b tgt=%h",
                 c, Stall_out, mem_req, PCSrc_out, BranchTarget_out, st, st, t.br & t.zf, t.add);
      end
      if (st) begin
        tests++;
        if ({mem_we, mem_addr, mem_wdata} !== {t.wr, eaddr, t.b2}) begin
          fails++;
          $display("FAIL mem_port c=%0d: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                   c, mem_we, mem_addr, mem_wdata, t.wr, eaddr, t.b2);
        end
      end
      if (c >= 1) begin
        tests++;
        if ({Regwrite_out, MemToReg_out, Misalign_out, ReadData_out, ALU_out, Mux_out} !== 72'h0) begin
          fails++;
          $display("FAIL bubble c=%0d: got rw=%b mtr=%b mis=%b rd=%h alu=%h mux=%0d, want all zero",
                   c, Regwrite_out, MemToReg_out, Misalign_out, ReadData_out, ALU_out, Mux_out);
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    tests++;
    if ({Regwrite_out, MemToReg_out, Misalign_out} !== {t.rw & !mis, t.mtr & !mis, mis}) begin
      fails++;
      $display("FAIL wb_ctrl: got rw=%b mtr=%b mis=%b, want rw=%b mtr=%b mis=%b",
               Regwrite_out, MemToReg_out, Misalign_out, t.rw & !mis, t.mtr & !mis, mis);
    end
    if (!mis) begin
      tests++;
      if ({ReadData_out, ALU_out, Mux_out} !== {ld ? t.rdata : 32'h0, t.alu, t.mux}) begin
        fails++;
        $display("FAIL wb_data: got rd=%h alu=%h mux=%0d, want rd=%h alu=%h mux=%0d",
                 ReadData_out, ALU_out, Mux_out, ld ? t.rdata : 32'h0, t.alu, t.mux);
      end
    end
  endtask
  task automatic test_reset();
    instr_t t;
    t = blank(); t.br = 1'b1; t.zf = 1'b1; t.rd = 1'b1; t.rw = 1'b1;
    apply(t);
    mem_ack = 1'b0; mem_rdata = '0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if ({mem_req, Stall_out, PCSrc_out} !== 3'b000) begin
      fails++;
      $display("FAIL reset_comb: got req=%b stall=%b pcsrc=%b, want 000", mem_req, Stall_out, PCSrc_out);
    end
    tests++;
    if ({Regwrite_out, MemToReg_out, Misalign_out, ReadData_out, ALU_out, Mux_out} !== 72'h0) begin
      fails++;
      $display("FAIL reset_regs: got rw=%b mtr=%b mis=%b rd=%h alu=%h mux=%0d, want all zero",
               Regwrite_out, MemToReg_out, Misalign_out, ReadData_out, ALU_out, Mux_out);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(blank());
  endtask
  task automatic test_nonmem();
    instr_t t;
    t = blank(); t.alu = 32'h1234; t.mux = 5'd5; t.rw = 1'b1;
    exec(t, 0);
  endtask
  task automatic test_load();
    instr_t t;
    t = blank(); t.alu = 32'h40; t.rd = 1'b1; t.rw = 1'b1; t.mtr = 1'b1; t.mux = 5'd9; t.rdata = 32'hDEADBEEF;
    exec(t, 3);
  endtask
  task automatic test_store();
    instr_t t;
    t = blank(); t.alu = 32'h80; t.wr = 1'b1; t.b2 = 32'hA5A5A5A5; t.mux = 5'd3;
    exec(t, 0);
  endtask
  task automatic test_branch();
    instr_t t;
    t = blank(); t.br = 1'b1; t.zf = 1'b1; t.add = 32'h100;
    exec(t, 0);
    t.zf = 1'b0;
    exec(t, 0);
  endtask
  task automatic test_reset_in_wait();
    instr_t t;
    t = blank(); t.alu = 32'h44; t.rd = 1'b1; t.rw = 1'b1; t.mtr = 1'b1;
    apply(t);
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({mem_req, Stall_out} !== 2'b00) begin
      fails++;
      $display("FAIL rst_wait_comb: got req=%b stall=%b, want 00", mem_req, Stall_out);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(blank());
    mem_ack = 1'b1;
    #1;
    tests++;
    if ({mem_req, Stall_out, Regwrite_out, MemToReg_out, Misalign_out, ReadData_out, ALU_out, Mux_out} !== 74'h0) begin
      fails++;
      $display("FAIL rst_wait_after: got req=%b stall=%b rw=%b mtr=%b mis=%b rd=%h alu=%h mux=%0d, want all zero",
               mem_req, Stall_out, Regwrite_out, MemToReg_out, Misalign_out, ReadData_out, ALU_out, Mux_out);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    t = blank(); t.alu = 32'h5678; t.mux = 5'd17; t.rw = 1'b1;
    exec(t, 0);
  endtask
  task automatic test_misalign();
    instr_t t;
    t = blank(); t.alu = 32'h42; t.rd = 1'b1; t.rw = 1'b1; t.mtr = 1'b1; t.mux = 5'd7; t.rdata = 32'hCAFEF00D;
    exec(t, 1);
    t = blank(); t.alu = 32'h99; t.mux = 5'd1; t.rw = 1'b1;
    exec(t, 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 40; i++) exec(rand_instr(), int'($urandom_range(0, 4)));
  endtask
  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_branch();
    test_reset_in_wait();
    test_misalign();
    test_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
